// File: rtl/ex_wb_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_pkg
// Brief    : Shared widths, stage-register layout and writeback FSM states.
// Revision : 1.0
// ============================================================================
package cpu_pkg;

    localparam int DATA_W = 8;
    localparam int REG_W  = 3;
    localparam int PC_W   = 16;

    typedef enum logic [0:0] {
        RUN    = 1'b0,
        SQUASH = 1'b1
    } wb_state_e;

    typedef struct packed {
        logic              valid;
        logic              reg_write;
        logic              branch;
        logic [REG_W-1:0]  dest;
        logic [DATA_W-1:0] result;
        logic [PC_W-1:0]   target;
    } stage_t;

endpackage
`default_nettype wire

// File: rtl/ex_wb_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : ex_wb_stage_if
// Brief    : ALU-to-writeback bundle; slave is the stage, master the upstream.
// Revision : 1.0
// ============================================================================
interface ex_wb_stage_if
    import cpu_pkg::*;
();
    logic              valid_i;
    logic              stall_i;
    logic [DATA_W-1:0] alu_result_i;
    logic              alu_branch_i;
    logic [PC_W-1:0]   branch_target_i;
    logic [REG_W-1:0]  dest_reg_i;
    logic              reg_write_i;
    logic [REG_W-1:0]  src1_i;
    logic [REG_W-1:0]  src2_i;

    logic              wb_en_o;
    logic [REG_W-1:0]  wb_reg_o;
    logic [DATA_W-1:0] wb_data_o;
    logic              branch_o;
    logic [PC_W-1:0]   branchloc_o;
    logic              squashing_o;
    logic              fwd1_o;
    logic              fwd2_o;
    logic [DATA_W-1:0] fwd_data_o;
    logic [15:0]       retired_o;

    modport slave (
        input  valid_i, stall_i, alu_result_i, alu_branch_i, branch_target_i,
               dest_reg_i, reg_write_i, src1_i, src2_i,
        output wb_en_o, wb_reg_o, wb_data_o, branch_o, branchloc_o,
               squashing_o, fwd1_o, fwd2_o, fwd_data_o, retired_o
    );

    modport master (
        output valid_i, stall_i, alu_result_i, alu_branch_i, branch_target_i,
               dest_reg_i, reg_write_i, src1_i, src2_i,
        input  wb_en_o, wb_reg_o, wb_data_o, branch_o, branchloc_o,
               squashing_o, fwd1_o, fwd2_o, fwd_data_o, retired_o
    );
endinterface
`default_nettype wire

// File: rtl/ex_wb_stage_squash_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : squash_ctrl
// Brief    : RUN/SQUASH tracker discarding SQUASH_N accepts after a branch.
// Revision : 1.0
// ============================================================================
module squash_ctrl
    import cpu_pkg::*;
#(
    parameter int SQUASH_N = 2
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic acc_i,
    input  wire logic branch_i,
    output logic      run_o,
    output logic      squashing_o
);
    localparam logic [0:0] S_RUN    = 1'(RUN);
    localparam logic [0:0] S_SQUASH = 1'(SQUASH);
    localparam logic [2:0] C_SQUASH_N = 3'(SQUASH_N);

    logic [0:0] state_q, state_d;
    logic [2:0] cnt_q, cnt_d;

    // Only accepted inputs consume squash slots; stalls and bubbles leave the count alone.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == S_RUN) begin
            if (branch_i) begin
                state_d = S_SQUASH;
                cnt_d   = C_SQUASH_N;
            end
        end else if (acc_i) begin
            if (cnt_q == 3'd1) begin
                state_d = S_RUN;
                cnt_d   = 3'd0;
            end else begin
                cnt_d = cnt_q - 3'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_RUN;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign run_o       = (state_q == S_RUN);
    assign squashing_o = (state_q == S_SQUASH);
endmodule
`default_nettype wire

// File: rtl/ex_wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : ex_wb_stage
// Brief    : EX->WB register with branch redirect, wrong-path squash, forwarding.
// Revision : 1.0
// ============================================================================
module ex_wb_stage
    import cpu_pkg::*;
#(
    parameter int SQUASH_N = 2
) (
    input  wire logic    clk,
    input  wire logic    rst,
    ex_wb_stage_if.slave bus
);
    stage_t      stage_q, stage_d;
    logic [15:0] retired_q, retired_d;
    logic        w_acc;
    logic        w_cap;
    logic        w_run;
    logic        w_wb_en;

    assign w_acc = bus.valid_i & ~bus.stall_i;
    assign w_cap = w_acc & w_run;

    squash_ctrl #(
        .SQUASH_N (SQUASH_N)
    ) u_squash_ctrl (
        .clk         (clk),
        .rst         (rst),
        .acc_i       (w_acc),
        .branch_i    (w_cap & bus.alu_branch_i),
        .run_o       (w_run),
        .squashing_o (bus.squashing_o)
    );

    // Payload fields keep their old value on bubbles so wb_reg/wb_data and branchloc hold.
    always_comb begin
        stage_d       = stage_q;
        stage_d.valid = w_cap;
        if (w_cap) begin
            stage_d.reg_write = bus.reg_write_i;
            stage_d.branch    = bus.alu_branch_i;
            stage_d.dest      = bus.dest_reg_i;
            stage_d.result    = bus.alu_result_i;
            if (bus.alu_branch_i) begin
                stage_d.target = bus.branch_target_i;
            end
        end
        retired_d = retired_q + 16'(w_cap);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_q   <= '0;
            retired_q <= 16'd0;
        end else begin
            stage_q   <= stage_d;
            retired_q <= retired_d;
        end
    end

    assign w_wb_en         = stage_q.valid & stage_q.reg_write;
    assign bus.wb_en_o     = w_wb_en;
    assign bus.wb_reg_o    = stage_q.dest;
    assign bus.wb_data_o   = stage_q.result;
    assign bus.branch_o    = stage_q.valid & stage_q.branch;
    assign bus.branchloc_o = stage_q.target;
    assign bus.retired_o   = retired_q;

    // The regfile returns the old value in the write cycle, so readers take this path instead.
    assign bus.fwd1_o     = w_wb_en & (bus.src1_i == stage_q.dest);
    assign bus.fwd2_o     = w_wb_en & (bus.src2_i == stage_q.dest);
    assign bus.fwd_data_o = stage_q.result;
endmodule
`default_nettype wire

// File: tb/tb_ex_wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_wb_stage
// Brief    : Self-checking bench for ex_wb_stage against a transaction-level model.
// Revision : 1.0
// ============================================================================
module tb_ex_wb_stage;
    localparam int SQN = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    ex_wb_stage_if bus();

    ex_wb_stage #(.SQUASH_N(SQN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference: a taken branch simply discards the next SQN accepted inputs.
    int          m_skip;
    logic        m_valid, m_rw, m_br;
    logic [2:0]  m_reg;
    logic [7:0]  m_data;
    logic [15:0] m_loc, m_ret;

    function automatic void model_reset();
        m_skip = 0; m_valid = 0; m_rw = 0; m_br = 0;
        m_reg = 0; m_data = 0; m_loc = 0; m_ret = 0;
    endfunction

    function automatic void model_clk(logic v, logic s, logic br, logic rw,
                                      logic [7:0] res, logic [15:0] tgt, logic [2:0] dst);
        m_valid = 1'b0;
        if (v && !s) begin
            if (m_skip > 0) begin
                m_skip = m_skip - 1;
            end else begin
                m_valid = 1'b1; m_rw = rw; m_br = br; m_reg = dst; m_data = res;
                m_ret = m_ret + 16'd1;
                if (br) begin
                    m_loc  = tgt;
                    m_skip = SQN;
                end
            end
        end
    endfunction

    function automatic logic [55:0] exp_vec();
        logic en;
        en = m_valid & m_rw;
        return {en, m_reg, m_data, m_valid & m_br, m_loc, (m_skip > 0), m_ret,
                en & (bus.src1_i == m_reg), en & (bus.src2_i == m_reg), m_data};
    endfunction

    function automatic logic [55:0] dut_vec();
        return {bus.wb_en_o, bus.wb_reg_o, bus.wb_data_o, bus.branch_o, bus.branchloc_o,
                bus.squashing_o, bus.retired_o, bus.fwd1_o, bus.fwd2_o, bus.fwd_data_o};
    endfunction

    task automatic drive(input logic v, input logic s, input logic br, input logic rw,
                         input logic [7:0] res, input logic [15:0] tgt, input logic [2:0] dst);
        bus.valid_i = v; bus.stall_i = s; bus.alu_branch_i = br; bus.reg_write_i = rw;
        bus.alu_result_i = res; bus.branch_target_i = tgt; bus.dest_reg_i = dst;
        @(posedge clk);
        model_clk(v, s, br, rw, res, tgt, dst);
        #1;
    endtask

    task automatic test_reset();
        bus.valid_i = 0; bus.stall_i = 0; bus.alu_branch_i = 0; bus.reg_write_i = 0;
        bus.alu_result_i = 0; bus.branch_target_i = 0; bus.dest_reg_i = 0;
        bus.src1_i = 0; bus.src2_i = 0;
        rst = 1'b1;
        model_reset();
        #12;
        n_checks++;
        if (dut_vec() !== 56'd0) begin
            n_fail++; $display("FAIL reset_hold: got %h expected 0", dut_vec());
        end
        rst = 1'b0;
        drive(0, 0, 0, 0, 8'h00, 16'h0, 3'd0);
        n_checks++;
        if (dut_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL reset_idle: got %h expected %h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_writeback();
        drive(1, 0, 0, 1, 8'h5A, 16'h0, 3'd3);
        n_checks++;
        if ({bus.wb_en_o, bus.wb_reg_o, bus.wb_data_o, bus.retired_o} !== {1'b1, 3'd3, 8'h5A, 16'd1}) begin
            n_fail++; $display("FAIL writeback: got en=%b reg=%0d data=%h ret=%0d expected 1/3/5a/1",
                               bus.wb_en_o, bus.wb_reg_o, bus.wb_data_o, bus.retired_o);
        end
        drive(0, 0, 0, 1, 8'hFF, 16'h0, 3'd7);
        n_checks++;
        if ({bus.wb_en_o, bus.wb_reg_o, bus.wb_data_o} !== {1'b0, 3'd3, 8'h5A}) begin
            n_fail++; $display("FAIL writeback_bubble: got en=%b reg=%0d data=%h expected 0/3/5a",
                               bus.wb_en_o, bus.wb_reg_o, bus.wb_data_o);
        end
    endtask

    task automatic test_branch_squash();
        logic [7:0] vals [3];
        vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
        drive(1, 0, 1, 0, 8'h00, 16'h000A, 3'd0);
        n_checks++;
        if ({bus.branch_o, bus.branchloc_o, bus.squashing_o} !== {1'b1, 16'h000A, 1'b1}) begin
            n_fail++; $display("FAIL branch_pulse: got br=%b loc=%h sq=%b expected 1/000a/1",
                               bus.branch_o, bus.branchloc_o, bus.squashing_o);
        end
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0, 1, vals[i], 16'h0, 3'd1);
            n_checks++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL squash_seq%0d: got %h expected %h", i, dut_vec(), exp_vec());
            end
        end
        n_checks++;
        if ({bus.wb_en_o, bus.wb_data_o, bus.branch_o, bus.branchloc_o} !== {1'b1, 8'h33, 1'b0, 16'h000A}) begin
            n_fail++; $display("FAIL squash_last: got en=%b data=%h br=%b loc=%h expected 1/33/0/000a",
                               bus.wb_en_o, bus.wb_data_o, bus.branch_o, bus.branchloc_o);
        end
    endtask

    task automatic test_stall_squash();
        drive(1, 0, 1, 1, 8'h01, 16'h0100, 3'd2);
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 0, 1, 8'h02, 16'h0, 3'd2);
            n_checks++;
            if ({bus.squashing_o, bus.wb_en_o} !== 2'b10 || dut_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL stall_squash%0d: got %h expected %h", i, dut_vec(), exp_vec());
            end
        end
        drive(1, 0, 1, 1, 8'h03, 16'hBEEF, 3'd2);
        n_checks++;
        if ({bus.squashing_o, bus.wb_en_o, bus.branch_o} !== 3'b100) begin
            n_fail++; $display("FAIL stall_acc1: got sq=%b en=%b br=%b expected 1/0/0",
                               bus.squashing_o, bus.wb_en_o, bus.branch_o);
        end
        drive(1, 0, 0, 1, 8'h04, 16'h0, 3'd2);
        n_checks++;
        if ({bus.squashing_o, bus.wb_en_o, bus.branchloc_o} !== {1'b0, 1'b0, 16'h0100}) begin
            n_fail++; $display("FAIL stall_acc2: got sq=%b en=%b loc=%h expected 0/0/0100",
                               bus.squashing_o, bus.wb_en_o, bus.branchloc_o);
        end
        drive(1, 0, 0, 1, 8'h05, 16'h0, 3'd4);
        n_checks++;
        if ({bus.wb_en_o, bus.wb_reg_o, bus.wb_data_o} !== {1'b1, 3'd4, 8'h05}) begin
            n_fail++; $display("FAIL stall_resume: got en=%b reg=%0d data=%h expected 1/4/05",
                               bus.wb_en_o, bus.wb_reg_o, bus.wb_data_o);
        end
    endtask

    task automatic test_forwarding();
        drive(1, 0, 0, 1, 8'h7F, 16'h0, 3'd5);
        bus.src1_i = 3'd5; bus.src2_i = 3'd2;
        #1;
        n_checks++;
        if ({bus.fwd1_o, bus.fwd2_o, bus.fwd_data_o} !== {1'b1, 1'b0, 8'h7F}) begin
            n_fail++; $display("FAIL fwd_hit: got f1=%b f2=%b d=%h expected 1/0/7f",
                               bus.fwd1_o, bus.fwd2_o, bus.fwd_data_o);
        end
        bus.src2_i = 3'd5;
        #1;
        n_checks++;
        if ({bus.fwd1_o, bus.fwd2_o} !== 2'b11) begin
            n_fail++; $display("FAIL fwd_both: got f1=%b f2=%b expected 1/1", bus.fwd1_o, bus.fwd2_o);
        end
        drive(1, 0, 0, 0, 8'h7F, 16'h0, 3'd5);
        n_checks++;
        if ({bus.fwd1_o, bus.fwd2_o} !== 2'b00) begin
            n_fail++; $display("FAIL fwd_nowrite: got f1=%b f2=%b expected 0/0", bus.fwd1_o, bus.fwd2_o);
        end
        bus.src1_i = 3'd0; bus.src2_i = 3'd0;
    endtask

    task automatic test_async_reset();
        drive(1, 0, 1, 1, 8'h66, 16'h1234, 3'd6);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        n_checks++;
        if (dut_vec() !== 56'd0) begin
            n_fail++; $display("FAIL async_reset: got %h expected 0", dut_vec());
        end
        #2;
        rst = 1'b0;
        drive(1, 0, 0, 1, 8'h44, 16'h0, 3'd6);
        n_checks++;
        if ({bus.wb_en_o, bus.wb_reg_o, bus.wb_data_o, bus.squashing_o, bus.retired_o} !==
            {1'b1, 3'd6, 8'h44, 1'b0, 16'd1}) begin
            n_fail++; $display("FAIL async_release: got en=%b reg=%0d data=%h sq=%b ret=%0d expected 1/6/44/0/1",
                               bus.wb_en_o, bus.wb_reg_o, bus.wb_data_o, bus.squashing_o, bus.retired_o);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            bus.src1_i = 3'($urandom); bus.src2_i = 3'($urandom);
            drive(($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 6) == 0), 1'($urandom),
                  8'($urandom), 16'($urandom), 3'($urandom));
            n_checks++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL random%0d: got %h expected %h", i, dut_vec(), exp_vec());
            end
        end
        bus.src1_i = 3'd0; bus.src2_i = 3'd0;
    endtask

    task automatic test_counter_wrap();
        #2; rst = 1'b1; #1; model_reset(); #2; rst = 1'b0;
        for (int i = 0; i < 65535; i++) begin
            drive(1, 0, 0, 1, 8'(i), 16'h0, 3'(i));
        end
        n_checks++;
        if (bus.retired_o !== 16'hFFFF || dut_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL wrap_max: got ret=%h expected ffff", bus.retired_o);
        end
        drive(1, 0, 0, 1, 8'hAB, 16'h0, 3'd1);
        n_checks++;
        if (bus.retired_o !== 16'h0000 || dut_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL wrap_zero: got ret=%h expected 0000", bus.retired_o);
        end
    endtask

    initial begin
        test_reset();
        test_writeback();
        test_branch_squash();
        test_stall_squash();
        test_forwarding();
        test_async_reset();
        test_random();
        test_counter_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/ex_wb_stage.md
Name: ex_wb_stage

Overview:
- Pipeline stage directly downstream of the alu: registers each ALU result and drives the regfile write port (writeback).
- Turns a taken ALU branch into a one-cycle redirect to fetch.
- Squashes the wrong-path instructions already in flight after a taken branch.
- Provides same-cycle forwarding of the in-flight writeback value to the regfile read path.

Parameters:
- DATA_W, 8, register/ALU data width
- REG_W, 3, register address width (8 registers)
- PC_W, 16, program counter / branch target width
- SQUASH_N, 2, number of accepted instructions discarded after a taken branch (1..7)

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- valid_i  input  1  upstream presents an executed instruction this cycle
- stall_i  input  1  upstream holds; the current input is not consumed
- alu_result_i  input  DATA_W  ALU output
- alu_branch_i  input  1  ALU branch-taken flag
- branch_target_i  input  PC_W  target PC for a taken branch
- dest_reg_i  input  REG_W  destination register
- reg_write_i  input  1  instruction writes dest_reg_i
- src1_i, src2_i  input  REG_W each  registers being read this cycle (for the forward compare)
- wb_en_o  output  1  regfile write enable
- wb_reg_o  output  REG_W  regfile destination
- wb_data_o  output  DATA_W  regfile write data
- branch_o  output  1  one-cycle redirect pulse to fetch branch_i
- branchloc_o  output  PC_W  redirect target to fetch branchloc_i
- squashing_o  output  1  high while in SQUASH state
- fwd1_o, fwd2_o  output  1 each  src1_i / src2_i match the in-flight writeback
- fwd_data_o  output  DATA_W  forwarded value (equals wb_data_o)
- retired_o  output  16  count of instructions that completed writeback or branch

Behaviour:
- Reset (async, rst=1): every output 0; state RUN; squash counter 0; stage register invalid.
- Accept condition: acc = valid_i & ~stall_i.
- Capture condition: cap = acc & (state==RUN). When cap is 0, the stage register loads a bubble (valid=0).
- Latency: exactly 1 cycle from the accepted input to the registered outputs.
- Writeback:
  - wb_en_o = stage valid & captured reg_write.
  - wb_reg_o and wb_data_o hold the captured values; they hold their last value when invalid.
  - Each instruction asserts wb_en_o for exactly one cycle.
- Branch:
  - If cap & alu_branch_i, then next cycle branch_o=1 and branchloc_o=branch_target_i.
  - branch_o returns to 0 after one cycle; branchloc_o holds its value.
  - A branching instruction with reg_write_i=1 also writes back in the same cycle.
- States:
  - RUN -> SQUASH on cap & alu_branch_i; the counter loads SQUASH_N.
  - In SQUASH, each acc discards the input (no write, no branch, not counted) and decrements the counter.
  - Stalled or invalid cycles do not decrement.
  - Counter 1 plus acc -> RUN on the next edge. The first accepted input after that is captured normally.
  - A branch flag on a squashed input is ignored.
- Forwarding (combinational from the stage register):
  - fwd1_o = wb_en_o & (src1_i==wb_reg_o); fwd2_o likewise for src2_i.
  - fwd_data_o = wb_data_o.
  - Required because regfile reads in the write cycle return the old value.
- retired_o increments by 1 on every cycle the stage register is valid; it wraps 0xFFFF -> 0.
- Simultaneous events:
  - stall_i with valid_i: no capture, no squash decrement.
  - Reset during SQUASH: returns to RUN with no pending redirect.
- Reset asserted mid-pulse: branch_o and wb_en_o drop immediately (asynchronous).

Decomposition:
- Shared package cpu_pkg holds:
  - widths DATA_W, REG_W, PC_W;
  - typedef stage_t: valid, reg_write, branch, dest, result, target;
  - enum wb_state_e: RUN, SQUASH.
- The forward comparators stay inline.
- One sub-module: squash_ctrl, which holds the state, the counter and squashing_o.

Test Plan:
- Writeback: acc with dest=3, result=0x5A, reg_write=1 -> next cycle wb_en_o=1, wb_reg_o=3, wb_data_o=0x5A, retired_o=1; following bubble -> wb_en_o=0.
- Branch and squash: branch_target=0x000A, alu_branch=1, then 3 back-to-back valid writes to r1 (0x11, 0x22, 0x33):
  - branch_o high one cycle with branchloc_o=0x000A;
  - 0x11 and 0x22 dropped, squashing_o high for 2 accepts;
  - 0x33 written.
- Stall during SQUASH: branch, then valid with stall_i=1 for 4 cycles -> counter unchanged, squashing_o stays 1; two unstalled accepts -> RUN.
- Forwarding: in-flight write r5=0x7F, src1_i=5, src2_i=2 -> fwd1_o=1, fwd2_o=0, fwd_data_o=0x7F; reg_write=0 -> both 0.
- Async reset in SQUASH: assert rst between clock edges -> all outputs 0 immediately; after release, the first valid write is captured (not squashed).
- Counter wrap: preload via 65536 valid writes -> retired_o returns to 0x0000.
